// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button sync, debounce, and press/release/click/long-press pulse generation
module btn_conditioner #(
  parameter int N_BTN        = 8,
  parameter int DEBOUNCE_CYC = 2_000_000,
  parameter int LONG_CYC     = 300_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_click,
  output logic [N_BTN-1:0] btn_long
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int LW = $clog2(LONG_CYC + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYC);
  localparam logic [LW-1:0] LMAX = LW'(LONG_CYC);
  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
  for (genvar g = 0; g < N_BTN; g++) begin : ch
    logic          sync1_q, sync2_q, level_q, level_d;
    logic          press_q, press_d, release_q, release_d, click_q, click_d, long_q, long_d;
    logic [DW-1:0] dcnt_q, dcnt_d, dcnt_inc;
    logic [LW-1:0] lcnt_q, lcnt_d, lcnt_inc;
    state_t        state_q, state_d;
    logic          acc, rise, fall, hit;
    always_comb begin
      dcnt_inc  = dcnt_q + 1'b1;
      lcnt_inc  = lcnt_q + 1'b1;
      acc       = (sync2_q != level_q) && (dcnt_inc == DMAX);
      rise      = acc && sync2_q;
      fall      = acc && !sync2_q;
      // a release accepted on the same edge the hold time expires beats the long press
      hit       = (state_q == HELD) && !fall && (lcnt_inc == LMAX);
      level_d   = acc ? sync2_q : level_q;
      dcnt_d    = (sync2_q == level_q || acc) ? '0 : dcnt_inc;
      lcnt_d    = rise ? '0 : (state_q == HELD) ? lcnt_inc : lcnt_q;
      state_d   = rise ? HELD : fall ? IDLE : hit ? LONG : state_q;
      press_d   = rise;
      release_d = fall;
      click_d   = fall && (state_q == HELD);
      long_d    = hit;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        level_q   <= 1'b0;
        dcnt_q    <= '0;
        lcnt_q    <= '0;
        state_q   <= IDLE;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        click_q   <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        sync1_q   <= btn_raw[g];
        sync2_q   <= sync1_q;
        level_q   <= level_d;
        dcnt_q    <= dcnt_d;
        lcnt_q    <= lcnt_d;
        state_q   <= state_d;
        press_q   <= press_d;
        release_q <= release_d;
        click_q   <= click_d;
        long_q    <= long_d;
      end
    end
    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
    assign btn_click[g]   = click_q;
    assign btn_long[g]    = long_q;
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: scoreboard bench; expected pulse events are queued as stimulus is driven
module tb_btn_conditioner;
  localparam int N = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] raw = '0;
  logic [N-1:0] lvl, prs, rel, clk_o, lng;
  int           e = 0, n_cmp = 0, n_bad = 0, t, a;
  int           sbq[$];
  logic [8:0]   bseq;
  btn_conditioner #(.N_BTN(N), .DEBOUNCE_CYC(4), .LONG_CYC(20)) dut (
    .clk(clk), .rst(rst), .btn_raw(raw), .btn_level(lvl), .btn_press(prs),
    .btn_release(rel), .btn_click(clk_o), .btn_long(lng)
  );
  always #5 clk = ~clk;
  always @(posedge clk) e <= e + 1;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
    end
  endtask
  function automatic void push(int tt, int k, int c);
    sbq.push_back((tt << 8) | (k << 4) | c);
  endfunction
  task automatic wait_to(int tt);
    while (e < tt) @(negedge clk);
  endtask
  // event code: edge<<8 | kind<<4 | channel, kind 0=press 1=release 2=click 3=long
  always @(negedge clk) begin
    logic [3:0][N-1:0] p;
    int ev;
    p = {lng, clk_o, rel, prs};
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < N; c++)
        if (p[k][c]) begin
          ev = (e << 8) | (k << 4) | c;
          if (sbq.size() == 0) check("unexpected_evt", 64'(ev), 64'hffff_ffff);
          else check("evt", 64'(ev), 64'(sbq.pop_front()));
        end
  end
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    check("reset_out", {lvl, prs, rel, clk_o, lng}, 0);
    rst = 1'b0;
    // clean press and click on ch2
    @(negedge clk); t = e; raw[2] = 1'b1; push(t + 6, 0, 2);
    wait_to(t + 5); check("clean_pre", lvl, 0);
    wait_to(t + 6); check("clean_lvl", lvl, 8'h04);
    wait_to(t + 7); check("clean_hold", lvl, 8'h04);
    wait_to(t + 14); raw[2] = 1'b0; push(t + 20, 1, 2); push(t + 20, 2, 2);
    wait_to(t + 20); check("clean_rel_lvl", lvl, 0);
    wait_to(t + 25);
    // bounce on ch0: final rising sample at edge t+6
    bseq = 9'b111101101;
    t = e; push(t + 11, 0, 0);
    for (int i = 0; i < 9; i++) begin
      raw[0] = bseq[i];
      @(negedge clk);
    end
    wait_to(t + 10); check("bounce_pre", lvl, 0);
    wait_to(t + 11); check("bounce_lvl", lvl, 8'h01);
    raw[0] = 1'b0; push(t + 17, 1, 0); push(t + 17, 2, 0);
    wait_to(t + 22);
    // short click on ch1
    t = e; a = t + 6; raw[1] = 1'b1; push(a, 0, 1);
    wait_to(a + 10); raw[1] = 1'b0; push(a + 16, 1, 1); push(a + 16, 2, 1);
    wait_to(a + 25); check("short_lvl", lvl, 0);
    // long press on ch1
    t = e; a = t + 6; raw[1] = 1'b1; push(a, 0, 1); push(a + 20, 3, 1);
    wait_to(a + 30); check("long_lvl", lvl, 8'h02);
    raw[1] = 1'b0; push(a + 36, 1, 1);
    wait_to(a + 40); check("long_rel_lvl", lvl, 0);
    // ch4 release accepted on the very edge the long press would fire
    t = e; a = t + 6; raw[4] = 1'b1; push(a, 0, 4);
    wait_to(a + 14); raw[4] = 1'b0; push(a + 20, 1, 4); push(a + 20, 2, 4);
    wait_to(a + 26);
    // reset mid-hold on ch3
    t = e; a = t + 6; raw[3] = 1'b1; push(a, 0, 3);
    wait_to(a + 3); check("rsthold_lvl", lvl, 8'h08);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rsthold_out", {lvl, prs, rel, clk_o, lng}, 0);
    push(a + 10, 0, 3);
    wait_to(a + 9); check("rsthold_pre", lvl, 0);
    wait_to(a + 10); check("rsthold_lvl2", lvl, 8'h08);
    wait_to(a + 12); raw[3] = 1'b0; push(a + 18, 1, 3); push(a + 18, 2, 3);
    wait_to(a + 22);
    // simultaneous ch0 and ch7; click on ch0 leaves ch7 long timing intact
    t = e; a = t + 6; raw[0] = 1'b1; raw[7] = 1'b1; push(a, 0, 0); push(a, 0, 7);
    wait_to(a); check("sim_lvl", lvl, 8'h81);
    wait_to(a + 5); raw[0] = 1'b0; push(a + 11, 1, 0); push(a + 11, 2, 0); push(a + 20, 3, 7);
    wait_to(a + 25); check("sim_lvl2", lvl, 8'h80);
    raw[7] = 1'b0; push(a + 31, 1, 7);
    wait_to(a + 36);
    check("drain", 64'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Per-button input conditioner between the board push-buttons (up/left/middle/right/down, page keys, handClean) and the hood top level. Each raw input is synchronised, debounced, and turned into a clean level plus single-cycle press, release, click (short press) and long-press pulses. Downstream FSMs (on/off, mode, time adjust, gesture) consume only these pulses, never raw buttons.

## Interface
- N_BTN, 8, number of independent button channels
- DEBOUNCE_CYC, 2_000_000, consecutive stable cycles required to accept a level change (20 ms @ 100 MHz); must be ≥ 2
- LONG_CYC, 300_000_000, held cycles after accepted press before long-press fires (3 s @ 100 MHz); must be > DEBOUNCE_CYC

- clk  in  1  system clock (single clock domain)
- rst  in  1  reset, synchronous, active-high
- btn_raw  in  N_BTN  raw asynchronous button inputs, 1 = pressed
- btn_level  out  N_BTN  debounced level
- btn_press  out  N_BTN  1-cycle pulse on accepted 0→1
- btn_release  out  N_BTN  1-cycle pulse on accepted 1→0
- btn_click  out  N_BTN  1-cycle pulse on accepted release when long-press did not fire during that press
- btn_long  out  N_BTN  1-cycle pulse when held LONG_CYC cycles; at most once per press

## Operation
- Channels are fully independent; identical logic replicated N_BTN times.
- Sync: two-flop synchroniser sync1→sync2 per channel; both reset to 0.
- Debounce counter dcnt, width clog2(DEBOUNCE_CYC+1): on each edge, if sync2 == btn_level then dcnt ← 0; else dcnt ← dcnt+1, and when dcnt+1 == DEBOUNCE_CYC: btn_level ← sync2, dcnt ← 0, corresponding edge pulse asserted.
- Any single cycle with sync2 == btn_level (glitch/bounce) restarts the count from 0.
- Per-channel state: IDLE (level 0), HELD (level 1, long not fired), LONG (level 1, long fired).
  - IDLE→HELD on accepted rise: btn_press.
  - HELD→LONG when lcnt reaches LONG_CYC: btn_long.
  - HELD→IDLE on accepted fall: btn_release + btn_click.
  - LONG→IDLE on accepted fall: btn_release only.
- Long counter lcnt, width clog2(LONG_CYC+1): cleared to 0 on accepted rise; increments every edge in HELD; held (no wrap) in LONG and IDLE.
- Pulses are registered outputs, high for exactly one cycle; never two consecutive cycles on the same output.
- No stuck/timeout handling: a button held indefinitely stays in LONG with btn_level = 1.

## Timing
- Reset values: btn_level, btn_press, btn_release, btn_click, btn_long all 0; sync1, sync2, dcnt, lcnt 0; state IDLE.
- Raw change captured by sync1 at edge 0 → btn_level and edge pulse visible after edge DEBOUNCE_CYC+1; pulse drops after edge DEBOUNCE_CYC+2.
- btn_long asserted after edge (accepted-rise edge + LONG_CYC).
- Release and click are asserted in the same cycle.
- Reset mid-press: all outputs forced to 0 at the reset edge, with no release or click emitted. If raw stays high, a fresh btn_press follows DEBOUNCE_CYC+2 edges after the last reset edge.
- Reset mid-debounce: the partial count is discarded.
- Simultaneous presses on different channels produce pulses in the same cycle, with no priority or arbitration.
- Release accepted in the same cycle lcnt would reach LONG_CYC: release wins. btn_click is asserted, btn_long is not.

## Test plan
(DEBOUNCE_CYC=4, LONG_CYC=20 in bench)
- Clean press: raw[2] 0→1 sampled at edge 0 → btn_level[2] and btn_press[2] high after edge 5, btn_press[2] low after edge 6, other channels stay 0.
- Bounce: raw[0] toggles 1,0,1,1,0,1,1,1,1 on successive edges → single btn_press[0], asserted 5 edges after the final rising sample; no release.
- Short click: press held 10 cycles after acceptance, then released → btn_release[1] and btn_click[1] in the same cycle; btn_long[1] never asserts.
- Long press: hold 30 cycles after acceptance → btn_long[1] exactly once, 20 edges after acceptance. Release → btn_release[1] only, btn_click[1] = 0.
- Reset mid-hold: rst for 1 cycle while btn_level[3]=1 and raw held → outputs 0 after the reset edge with no release pulse; btn_press[3] reasserts 6 edges after the reset edge.
- Simultaneous: raw[0] and raw[7] rise together → both btn_press asserted in the same cycle; click on one does not disturb the other's lcnt.
